// File: rtl/cu_pipe.sv
// Pipelined RV32I control unit: combinational ID decode, registered ID/EX controls,
// EX-stage branch/jump resolution with flush generation and a saturating redirect counter.
module cu_pipe #(
  parameter int unsigned ALUCTRL_W = 4,
  parameter bit          EN_MUL    = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr_d,
  input  logic                 valid_d,
  input  logic                 stall,
  input  logic                 Zero_e,
  input  logic                 LtS_e,
  input  logic                 LtU_e,
  output logic [2:0]           ImmSrc_d,
  output logic                 RegWrite_e,
  output logic                 MemWrite_e,
  output logic [1:0]           ResultSrc_e,
  output logic                 ALUsrc_e,
  output logic [ALUCTRL_W-1:0] ALUctrl_e,
  output logic [1:0]           PCsrc_e,
  output logic                 Flush,
  output logic                 illegal_e,
  output logic [CNT_W-1:0]     redirect_cnt
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluAnd   = 4'b0010;
  localparam logic [3:0] AluOr    = 4'b0011;
  localparam logic [3:0] AluXor   = 4'b0100;
  localparam logic [3:0] AluSll   = 4'b0101;
  localparam logic [3:0] AluSrl   = 4'b0110;
  localparam logic [3:0] AluSra   = 4'b0111;
  localparam logic [3:0] AluSlt   = 4'b1000;
  localparam logic [3:0] AluSltu  = 4'b1001;
  localparam logic [3:0] AluPassb = 4'b1010;
  localparam logic [3:0] AluMul   = 4'b1011;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       illegal;
    logic [2:0] funct3;
  } ctl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  ctl_t       dec;
  ctl_t       ex_q;
  logic       taken;
  logic [CNT_W-1:0] cnt_q;
  logic       unused_instr;

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign funct7 = instr_d[31:25];
  // Register specifiers and immediates are handled by the datapath.
  assign unused_instr = ^{instr_d[24:15], instr_d[11:7]};

  // alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  always_comb begin
    dec      = '0;
    ImmSrc_d = 3'b000;
    case (opcode)
      OpR: begin
        if (funct7 == 7'b0000001) begin
          if (EN_MUL && funct3 == 3'b000) begin
            dec.reg_write = 1'b1;
            dec.alu_ctrl  = AluMul;
          end else begin
            dec.illegal = 1'b1;
          end
        end else begin
          dec.reg_write = 1'b1;
          dec.alu_ctrl  = alu_op(funct3, funct7[5]);
        end
      end
      OpI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = alu_op(funct3, funct3 == 3'b101 && funct7[5]);
      end
      OpLoad: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b01;
        dec.alu_src    = 1'b1;
        dec.alu_ctrl   = AluAdd;
      end
      OpStore: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = AluAdd;
        ImmSrc_d      = 3'b001;
      end
      OpBranch: begin
        if (funct3[2:1] == 2'b01) begin
          dec.illegal = 1'b1;
        end else begin
          dec.branch   = 1'b1;
          dec.alu_ctrl = AluSub;
          dec.funct3   = funct3;
          ImmSrc_d     = 3'b010;
        end
      end
      OpJal: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
        ImmSrc_d       = 3'b100;
      end
      OpJalr: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.alu_src    = 1'b1;
        dec.alu_ctrl   = AluAdd;
        dec.jalr       = 1'b1;
      end
      OpLui: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = AluPassb;
        ImmSrc_d      = 3'b011;
      end
      OpAuipc: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = AluAdd;
        ImmSrc_d      = 3'b011;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Flush wins over stall so a held ID instruction is squashed on redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (Flush) begin
      ex_q <= '0;
    end else if (!stall) begin
      ex_q <= valid_d ? dec : '0;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (ex_q.funct3)
      3'b000:  taken = Zero_e;
      3'b001:  taken = !Zero_e;
      3'b100:  taken = LtS_e;
      3'b101:  taken = !LtS_e;
      3'b110:  taken = LtU_e;
      3'b111:  taken = !LtU_e;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    PCsrc_e = 2'b00;
    if (ex_q.jalr) begin
      PCsrc_e = 2'b10;
    end else if (ex_q.jump || (ex_q.branch && taken)) begin
      PCsrc_e = 2'b01;
    end
  end

  assign Flush = (PCsrc_e != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (Flush && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign RegWrite_e   = ex_q.reg_write;
  assign MemWrite_e   = ex_q.mem_write;
  assign ResultSrc_e  = ex_q.result_src;
  assign ALUsrc_e     = ex_q.alu_src;
  assign ALUctrl_e    = ALUCTRL_W'(ex_q.alu_ctrl);
  assign illegal_e    = ex_q.illegal;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_cu_pipe.sv
// Scoreboard bench for cu_pipe: two instances (no MUL / 16-bit counter, MUL / 2-bit counter)
// driven in lockstep and checked against an instruction-level reference model.
module tb_cu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_d = '0;
  logic        valid_d = 1'b0, stall = 1'b0, Zero_e = 1'b0, LtS_e = 1'b0, LtU_e = 1'b0;

  logic [2:0]  a_imm, b_imm;
  logic        a_rw, a_mw, a_as, a_fl, a_ill, b_rw, b_mw, b_as, b_fl, b_ill;
  logic [1:0]  a_rs, a_pc, b_rs, b_pc;
  logic [3:0]  a_alu, b_alu;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;

  cu_pipe #(.ALUCTRL_W(4), .EN_MUL(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .stall(stall),
    .Zero_e(Zero_e), .LtS_e(LtS_e), .LtU_e(LtU_e), .ImmSrc_d(a_imm), .RegWrite_e(a_rw),
    .MemWrite_e(a_mw), .ResultSrc_e(a_rs), .ALUsrc_e(a_as), .ALUctrl_e(a_alu),
    .PCsrc_e(a_pc), .Flush(a_fl), .illegal_e(a_ill), .redirect_cnt(a_cnt)
  );

  cu_pipe #(.ALUCTRL_W(4), .EN_MUL(1'b1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .stall(stall),
    .Zero_e(Zero_e), .LtS_e(LtS_e), .LtU_e(LtU_e), .ImmSrc_d(b_imm), .RegWrite_e(b_rw),
    .MemWrite_e(b_mw), .ResultSrc_e(b_rs), .ALUsrc_e(b_as), .ALUctrl_e(b_alu),
    .PCsrc_e(b_pc), .Flush(b_fl), .illegal_e(b_ill), .redirect_cnt(b_cnt)
  );

  typedef struct packed {
    logic [2:0] imm;
    logic       rw, mw;
    logic [1:0] rs;
    logic       asrc;
    logic [3:0] alu;
    logic       br, jal, jalr, ill;
    logic [2:0] f3;
  } ctl_t;

  typedef struct packed {
    logic [2:0]  imm;
    logic        rw, mw;
    logic [1:0]  rs;
    logic        asrc;
    logic [3:0]  alu;
    logic [1:0]  pc;
    logic        fl, ill;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } pair_t;

  pair_t       q[$];
  int          total = 0;
  int          bad = 0;
  ctl_t        ex_m[2];
  int unsigned cnt_m[2];
  int unsigned cmax[2] = '{65535, 3};

  // ALU code per funct3 when no alternate (SUB/SRA) form applies.
  logic [3:0] base_alu [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
  logic [6:0] ops [12] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111,
                           7'b0000000, 7'b0001111};

  localparam logic [31:0] IAdd   = {7'h00, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011};
  localparam logic [31:0] ISub   = {7'h20, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011};
  localparam logic [31:0] IAddi  = {7'h20, 5'd5, 5'd2, 3'b000, 5'd1, 7'b0010011};
  localparam logic [31:0] ISrai  = {7'h20, 5'd3, 5'd2, 3'b101, 5'd1, 7'b0010011};
  localparam logic [31:0] ILui   = {20'h12345, 5'd1, 7'b0110111};
  localparam logic [31:0] IJal   = {20'h00100, 5'd1, 7'b1101111};
  localparam logic [31:0] IJalr  = {12'h010, 5'd2, 3'b000, 5'd1, 7'b1100111};
  localparam logic [31:0] IMul   = {7'h01, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011};
  localparam logic [31:0] INop   = 32'h0000_0013;
  localparam logic [31:0] IZero  = 32'h0000_0000;

  function automatic ctl_t model_dec(input logic [31:0] i, input bit mul_ok);
    ctl_t       c = '0;
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    c.f3 = f3;
    case (op)
      7'b0110011: begin
        if (f7 == 7'h01) begin
          if (mul_ok && f3 == 3'd0) begin c.rw = 1; c.alu = 4'd11; end
          else c.ill = 1;
        end else begin
          c.rw  = 1;
          c.alu = (f7[5] && f3 == 3'd0) ? 4'd1 : (f7[5] && f3 == 3'd5) ? 4'd7 : base_alu[f3];
        end
      end
      7'b0010011: begin
        c.rw = 1; c.asrc = 1;
        c.alu = (f7[5] && f3 == 3'd5) ? 4'd7 : base_alu[f3];
      end
      7'b0000011: begin c.rw = 1; c.rs = 2'b01; c.asrc = 1; end
      7'b0100011: begin c.mw = 1; c.asrc = 1; c.imm = 3'b001; end
      7'b1100011: begin
        if (f3 == 3'd2 || f3 == 3'd3) c.ill = 1;
        else begin c.br = 1; c.alu = 4'd1; c.imm = 3'b010; end
      end
      7'b1101111: begin c.rw = 1; c.rs = 2'b10; c.jal = 1; c.imm = 3'b100; end
      7'b1100111: begin c.rw = 1; c.rs = 2'b10; c.asrc = 1; c.jalr = 1; end
      7'b0110111: begin c.rw = 1; c.asrc = 1; c.alu = 4'd10; c.imm = 3'b011; end
      7'b0010111: begin c.rw = 1; c.asrc = 1; c.imm = 3'b011; end
      default:    c.ill = 1;
    endcase
    return c;
  endfunction

  // flg = {Zero, LtS, LtU}
  function automatic logic [1:0] pc_of(input ctl_t c, input logic [2:0] flg);
    logic t;
    case (c.f3)
      3'd0: t = flg[2];
      3'd1: t = !flg[2];
      3'd4: t = flg[1];
      3'd5: t = !flg[1];
      3'd6: t = flg[0];
      3'd7: t = !flg[0];
      default: t = 0;
    endcase
    if (c.jalr) return 2'b10;
    if (c.jal || (c.br && t)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t expect_out(input int k, input logic [31:0] ins,
                                      input logic [2:0] flg);
    exp_t e;
    ctl_t c = ex_m[k];
    e.imm  = model_dec(ins, k == 1).imm;
    e.rw   = c.rw;
    e.mw   = c.mw;
    e.rs   = c.rs;
    e.asrc = c.asrc;
    e.alu  = c.alu;
    e.pc   = pc_of(c, flg);
    e.fl   = (e.pc != 2'b00);
    e.ill  = c.ill;
    e.cnt  = 16'(cnt_m[k]);
    return e;
  endfunction

  task automatic issue(input logic [31:0] ins, input logic v, input logic st,
                       input logic [2:0] flg);
    pair_t p;
    @(negedge clk);
    instr_d = ins; valid_d = v; stall = st; {Zero_e, LtS_e, LtU_e} = flg;
    p.a = expect_out(0, ins, flg);
    p.b = expect_out(1, ins, flg);
    q.push_back(p);
    for (int k = 0; k < 2; k++) begin
      if (pc_of(ex_m[k], flg) != 2'b00) begin
        if (cnt_m[k] < cmax[k]) cnt_m[k]++;
        ex_m[k] = '0;
      end else if (!st) begin
        ex_m[k] = v ? model_dec(ins, k == 1) : '0;
      end
    end
  endtask

  // Reset is raised between edges; outputs must clear before the next clock edge.
  task automatic do_reset(input logic [31:0] ins);
    pair_t p;
    @(negedge clk);
    instr_d = ins; valid_d = 1'b0; stall = 1'b0; {Zero_e, LtS_e, LtU_e} = 3'b000;
    #1 rst = 1'b1;
    ex_m[0] = '0; ex_m[1] = '0; cnt_m[0] = 0; cnt_m[1] = 0;
    p.a = expect_out(0, ins, 3'b000);
    p.b = expect_out(1, ins, 3'b000);
    q.push_back(p);
    #2 rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [6:0]  f7;
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:15], 3'($urandom_range(0, 7)), r[11:7], ops[$urandom_range(0, 11)]};
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t got(imm rw mw rs as alu pc fl ill cnt)=%h %b %b %b %b %h %b %b %b %0d required=%h %b %b %b %b %h %b %b %b %0d",
               name, $time, act.imm, act.rw, act.mw, act.rs, act.asrc, act.alu, act.pc,
               act.fl, act.ill, act.cnt, want.imm, want.rw, want.mw, want.rs, want.asrc,
               want.alu, want.pc, want.fl, want.ill, want.cnt);
    end
  endtask

  initial begin : monitor
    pair_t p;
    exp_t  aa, bb;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        p  = q.pop_front();
        aa = {a_imm, a_rw, a_mw, a_rs, a_as, a_alu, a_pc, a_fl, a_ill, a_cnt};
        bb = {b_imm, b_rw, b_mw, b_rs, b_as, b_alu, b_pc, b_fl, b_ill, 14'd0, b_cnt};
        check("dut_a", aa, p.a);
        check("dut_b", bb, p.b);
      end
    end
  end

  initial begin : driver
    logic [31:0] br;
    ex_m[0] = '0; ex_m[1] = '0; cnt_m[0] = 0; cnt_m[1] = 0;
    do_reset(INop);

    // Reset mid-stream with a JAL sitting in EX.
    issue(IJal, 1, 0, 3'b000);
    do_reset(INop);

    // Branch truth table: every funct3 against every flag combination.
    foreach (base_alu[f]) begin
      if (f != 2 && f != 3) begin
        for (int fl = 0; fl < 8; fl++) begin
          br = {7'h00, 5'd3, 5'd2, 3'(f), 5'd0, 7'b1100011};
          issue(br, 1, 0, 3'b000);
          issue(INop, 1, 0, 3'(fl));
        end
      end
    end

    // Stall holds ADD in EX, then BEQ redirects while stall is still high.
    br = {7'h00, 5'd3, 5'd2, 3'b000, 5'd0, 7'b1100011};
    issue(IAdd, 1, 0, 3'b000);
    repeat (3) issue(br, 1, 1, 3'b000);
    issue(br, 1, 0, 3'b000);
    issue(IAddi, 1, 1, 3'b100);
    issue(INop, 0, 0, 3'b000);

    // Decode spot checks, JALR, illegal and MUL.
    issue(ISub, 1, 0, 3'b000);
    issue(IAddi, 1, 0, 3'b000);
    issue(ISrai, 1, 0, 3'b000);
    issue(ILui, 1, 0, 3'b000);
    issue(IJalr, 1, 0, 3'b000);
    issue(IAdd, 1, 0, 3'b000);
    issue(IZero, 1, 0, 3'b000);
    issue(IMul, 1, 0, 3'b000);
    issue(INop, 1, 0, 3'b000);

    // Enough back-to-back redirects to saturate the 2-bit counter.
    repeat (6) issue(IJal, 1, 0, 3'b000);
    issue(INop, 0, 0, 3'b000);

    repeat (400) begin
      issue(rand_instr(), $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
            3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    #4;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
